// File: rtl/clk_div_sched.sv
// clk_div_sched -- run-time controller for an even-ratio clock divider.
//
// Owns the divide counter and a flop-driven divided output. Ratio changes
// arrive over a valid/ready handshake. While the divider is running, a new
// ratio is held pending and applied only at a period boundary, so the output
// never produces a runt or stretched phase. When enable drops, the current
// period is drained before the divider stops.
//
// Optional feature: define CLK_DIV_SCHED_ODD_EN to make odd ratios >= 3
// legal. For an odd ratio the high phase is floor(N/2) cycles. Without the
// macro, odd ratios are rejected through the cfg_err path.
//
// Parameters:
//   CNT_W        width of the ratio and the counter (legal ratios 2..2^CNT_W-1)
//   DEFAULT_DIV  ratio loaded at reset (must be a legal even value)
//
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   enable     level-sensitive run request
//   cfg_valid  ratio-change request valid
//   cfg_div    requested ratio N
//   cfg_ready  controller can accept a request
//   cfg_err    one-cycle pulse: accepted request was illegal and discarded
//   div_out    divided clock, period N, high for counts 1..N/2 (flop output)
//   div_pulse  one-cycle pulse in the first high cycle of each period
//   busy       controller is not idle
//   cur_div    ratio currently in effect
module clk_div_sched #(
    parameter int          CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_out,
    output logic             div_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [CNT_W-1:0] active_div, active_n;
    logic [CNT_W-1:0] pend_div, pend_div_n;
    logic             pend_vld, pend_vld_n;
    logic             div_n, pulse_n, err_n;
    logic             accept, acc_ok, wrap;

    function automatic logic is_legal(input logic [CNT_W-1:0] n);
`ifdef CLK_DIV_SCHED_ODD_EN
        return (n >= CNT_W'(2));
`else
        return (n >= CNT_W'(2)) && !n[0];
`endif
    endfunction

    // Number of high cycles per period; floor(N/2) covers odd ratios too.
    function automatic logic [CNT_W-1:0] half_of(input logic [CNT_W-1:0] n);
        return n >> 1;
    endfunction

    // A pending ratio blocks new requests; DRAIN only has room when empty.
    assign cfg_ready = (state == IDLE) || (state == RUN) ||
                       ((state == DRAIN) && !pend_vld);
    assign busy      = (state != IDLE);
    assign cur_div   = active_div;

    always_comb begin
        state_n    = state;
        count_n    = count;
        active_n   = active_div;
        pend_div_n = pend_div;
        pend_vld_n = pend_vld;

        accept = cfg_valid && cfg_ready;
        acc_ok = accept && is_legal(cfg_div);
        err_n  = accept && !is_legal(cfg_div);
        wrap   = (state != IDLE) && (count == active_div - CNT_W'(1));

        if (state != IDLE) begin
            count_n = wrap ? '0 : count + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                count_n = '0;
                // No period in flight, so a legal ratio takes effect at once.
                if (acc_ok) begin
                    active_n = cfg_div;
                end
                if (enable) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                // Accepting on a boundary edge still waits for the next one.
                if (acc_ok) begin
                    pend_div_n = cfg_div;
                    pend_vld_n = 1'b1;
                end
                if (!enable) begin
                    state_n = DRAIN;
                end else if (acc_ok) begin
                    state_n = PEND;
                end
            end
            PEND: begin
                if (wrap) begin
                    active_n   = pend_div;
                    pend_vld_n = 1'b0;
                    state_n    = enable ? RUN : DRAIN;
                end else if (!enable) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (wrap) begin
                    if (pend_vld) begin
                        active_n   = pend_div;
                        pend_vld_n = 1'b0;
                    end
                    if (enable) begin
                        // A request taken on this edge waits for the next boundary.
                        if (acc_ok) begin
                            pend_div_n = cfg_div;
                            pend_vld_n = 1'b1;
                            state_n    = PEND;
                        end else begin
                            state_n = RUN;
                        end
                    end else begin
                        // Stopping: nothing left to protect, load it directly.
                        if (acc_ok) begin
                            active_n = cfg_div;
                        end
                        state_n = IDLE;
                    end
                end else if (acc_ok) begin
                    pend_div_n = cfg_div;
                    pend_vld_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are registered from the next count so div_out is a flop.
        div_n   = (count_n != '0) && (count_n <= half_of(active_n));
        pulse_n = (count_n == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            count      <= '0;
            active_div <= DEF_DIV;
            pend_div   <= '0;
            pend_vld   <= 1'b0;
            div_out    <= 1'b0;
            div_pulse  <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            active_div <= active_n;
            pend_div   <= pend_div_n;
            pend_vld   <= pend_vld_n;
            div_out    <= div_n;
            div_pulse  <= pulse_n;
            cfg_err    <= err_n;
        end
    end

endmodule
